// File: rtl/uart_rx.sv
// uart_rx -- 8N1 UART receiver, LSB first, idle-high line.
//
// The asynchronous pin is brought into the clock domain by a two-flop
// synchroniser (rx_s). Every FSM decision uses rx_s, so decisions lag the
// pin by two cycles. The start bit is re-checked at its centre, and each
// data bit and the stop bit are sampled at their centres.
//
// Optional feature: define UART_RX_PARITY_EN to add one even-parity bit
// between the data and stop bits, sampled by a PARITY state and reported
// on o_parity_err.
//
// Ports:
//   i_clk        system clock, all logic on the rising edge
//   i_rst_n      synchronous active-low reset
//   i_rx         asynchronous serial input, idle high
//   o_data       last received byte, updated only together with o_valid
//   o_valid      one-cycle strobe: o_data holds a new byte with a good stop bit
//   o_frame_err  one-cycle strobe: stop bit sampled low, byte discarded
//   o_busy       high whenever the FSM is outside IDLE
//   o_parity_err (UART_RX_PARITY_EN only) pulses with o_valid on bad parity
//
// Output handshake: there is no ready input. o_valid and o_frame_err are
// single-cycle strobes that are never high together; a consumer must take
// o_data in the cycle o_valid is high (o_data then stays stable until the
// next o_valid).

module uart_rx #(
    parameter int unsigned INPUT_CLOCK_FREQ = 100_000_000,
    parameter int unsigned BAUD_RATE        = 9600,
    parameter int unsigned CYCLES_PER_BAUD  = INPUT_CLOCK_FREQ / BAUD_RATE,
    parameter int unsigned HALF_BAUD        = CYCLES_PER_BAUD / 2
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_rx,
    output logic [7:0] o_data,
    output logic       o_valid,
    output logic       o_frame_err,
    output logic       o_busy
`ifdef UART_RX_PARITY_EN
    ,
    output logic       o_parity_err
`endif
);

    localparam logic [31:0] HALF_LAST = 32'(HALF_BAUD - 1);
    localparam logic [31:0] BAUD_LAST = 32'(CYCLES_PER_BAUD - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4,
        S_BREAK  = 3'd5
    } state_t;

    // state_q is the FSM state register; it is the signal to probe when
    // following the receiver's progress through a frame.
    state_t      state_q;
    state_t      state_d;

    logic        rx_meta;
    logic        rx_s;
    logic [31:0] cnt_q;
    logic [2:0]  bit_idx_q;
    logic [7:0]  shift_q;
    logic [7:0]  data_q;
    logic        valid_q;
    logic        frame_err_q;

    // Decode strobes produced by the next-state logic.
    logic        enter_data;
    logic        take_bit;
    logic        good_stop;
    logic        bad_stop;

`ifdef UART_RX_PARITY_EN
    logic        take_parity;
    logic        par_q;
    logic        parity_err_q;
`endif

    // Two-flop synchroniser; both flops reset to the idle (high) level so
    // reset never looks like a start edge.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= i_rx;
            rx_s    <= rx_meta;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic. Counter compares use >= so that a corrupted counter
    // value still terminates the current bit instead of hanging the FSM.
    always_comb begin
        state_d    = state_q;
        enter_data = 1'b0;
        take_bit   = 1'b0;
        good_stop  = 1'b0;
        bad_stop   = 1'b0;
`ifdef UART_RX_PARITY_EN
        take_parity = 1'b0;
`endif
        case (state_q)
            S_IDLE: begin
                if (!rx_s) begin
                    state_d = S_START;
                end
            end
            S_START: begin
                if (cnt_q >= HALF_LAST) begin
                    if (!rx_s) begin
                        state_d    = S_DATA;
                        enter_data = 1'b1;
                    end else begin
                        // Line went back high before mid-bit: a glitch.
                        state_d = S_IDLE;
                    end
                end
            end
            S_DATA: begin
                if (cnt_q >= BAUD_LAST) begin
                    take_bit = 1'b1;
                    if (bit_idx_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                        state_d = S_PARITY;
`else
                        state_d = S_STOP;
`endif
                    end
                end
            end
            S_PARITY: begin
`ifdef UART_RX_PARITY_EN
                if (cnt_q >= BAUD_LAST) begin
                    take_parity = 1'b1;
                    state_d     = S_STOP;
                end
`else
                state_d = S_IDLE;
`endif
            end
            S_STOP: begin
                if (cnt_q >= BAUD_LAST) begin
                    if (rx_s) begin
                        good_stop = 1'b1;
                        // IDLE is re-entered at the stop-bit centre so a
                        // back-to-back start bit half a bit later is caught.
                        state_d   = S_IDLE;
                    end else begin
                        bad_stop = 1'b1;
                        state_d  = S_BREAK;
                    end
                end
            end
            S_BREAK: begin
                // Wait out a held-low line so a break yields one error only.
                if (rx_s) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Cycle counter: cleared on every state change and after each data bit,
    // otherwise counts every cycle outside IDLE.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            cnt_q <= 32'd0;
        end else if ((state_d != state_q) || take_bit) begin
            cnt_q <= 32'd0;
        end else if (state_q != S_IDLE) begin
            cnt_q <= cnt_q + 32'd1;
        end
    end

    // Data path: shift right with the new bit entering at bit 7, so the
    // first (LSB) bit on the wire ends up in bit 0.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            bit_idx_q <= 3'd0;
            shift_q   <= 8'h00;
        end else begin
            if (enter_data) begin
                bit_idx_q <= 3'd0;
            end else if (take_bit) begin
                bit_idx_q <= bit_idx_q + 3'd1;
            end
            if (take_bit) begin
                shift_q <= {rx_s, shift_q[7:1]};
            end
        end
    end

`ifdef UART_RX_PARITY_EN
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            par_q <= 1'b0;
        end else if (take_parity) begin
            par_q <= rx_s;
        end
    end
`endif

    // Registered result strobes; they appear the cycle after the stop-bit
    // sample, which is also the first cycle back in IDLE (or in BREAK).
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            data_q      <= 8'h00;
            valid_q     <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            valid_q     <= good_stop;
            frame_err_q <= bad_stop;
            if (good_stop) begin
                data_q <= shift_q;
            end
        end
    end

`ifdef UART_RX_PARITY_EN
    // Even parity: XOR over data plus parity bit must be zero.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            parity_err_q <= 1'b0;
        end else begin
            parity_err_q <= good_stop & ((^shift_q) ^ par_q);
        end
    end

    assign o_parity_err = parity_err_q;
`endif

    assign o_data      = data_q;
    assign o_valid     = valid_q;
    assign o_frame_err = frame_err_q;
    assign o_busy      = (state_q != S_IDLE);

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- 8-data-bit, 1-stop-bit UART receiver, LSB first, idle-high line; the receive half of the board serial link.
- Synchronises the asynchronous `i_rx` pin and validates the start bit at mid-bit.
- Samples each data bit at its centre and checks the stop bit.
- Presents each byte as a one-cycle `o_valid` strobe with `o_data` held stable until the next byte.

Parameters:
INPUT_CLOCK_FREQ, 100_000_000, frequency of `i_clk` in Hz.
BAUD_RATE, 9600, line bit rate.
CYCLES_PER_BAUD, INPUT_CLOCK_FREQ/BAUD_RATE (10416, truncated), clocks per bit period.
HALF_BAUD, CYCLES_PER_BAUD/2 (5208), clocks from start-edge detect to start-bit centre sample.

Ports:
i_clk  input  1  system clock; all logic on rising edge.
i_rst_n  input  1  synchronous, active-low reset.
i_rx  input  1  asynchronous serial input; idle high.
o_data  output  8  last received byte; updated only when `o_valid` is asserted.
o_valid  output  1  one-cycle pulse: `o_data` holds a new byte with a good stop bit.
o_frame_err  output  1  one-cycle pulse: stop bit sampled low; byte discarded.
o_busy  output  1  high whenever the FSM is not in IDLE.

Behaviour:
- Reset (`i_rst_n`=0 at a rising edge) forces:
  - FSM to IDLE; bit counter and cycle counter to 0.
  - Both synchroniser flops to 1.
  - `o_data`=8'h00, `o_valid`=0, `o_frame_err`=0, `o_busy`=0.
- Reset asserted mid-frame abandons the frame with no pulse. After release the FSM waits in IDLE for a fresh falling edge.
- Synchroniser: 2 flops, `i_rx` -> `rx_s`. All FSM decisions use `rx_s` only, so they lag the pin by 2 cycles.
- Cycle counter: 32 bits, cleared on every state entry, increments every cycle outside IDLE.
- States:
  - IDLE: when `rx_s`==0, go to START.
  - START: at count==HALF_BAUD-1:
    - if `rx_s`==0: go to DATA, bit index=0;
    - else (glitch): go to IDLE, no pulses.
  - DATA: at count==CYCLES_PER_BAUD-1:
    - shift `rx_s` into bit 7 of the shift register, shifting right, so the first bit ends in bit 0;
    - restart the count;
    - after the bit with index 7 is taken, go to STOP.
  - STOP: at count==CYCLES_PER_BAUD-1, sample `rx_s`:
    - if 1: next cycle `o_data`<=shift register, `o_valid`=1 for exactly one cycle; go to IDLE;
    - if 0: `o_frame_err`=1 for one cycle, `o_data` unchanged; go to BREAK.
  - BREAK: stay until `rx_s`==1, then go to IDLE. A held-low line (break) therefore produces exactly one `o_frame_err`, not repeated frames.
- Timing and back-to-back operation:
  - IDLE is re-entered at the stop-bit centre, so a start bit arriving half a bit later is accepted.
  - Back-to-back frames need no idle gap.
  - `o_valid` rises 2 + HALF_BAUD + 9*CYCLES_PER_BAUD + 1 cycles after the `i_rx` falling edge, ±1 for edge alignment.
- Pulse rules: `o_valid` and `o_frame_err` are never high together and never high for more than one cycle.
- `o_busy`: asserted the cycle after leaving IDLE. Deasserted the cycle IDLE is re-entered; held high through BREAK.
- Counter compares use `>=` so a corrupted counter cannot hang the FSM.

Optional Feature:
- Macro: UART_RX_PARITY_EN.
- When defined:
  - A PARITY state sits between DATA and STOP and samples one even-parity bit at its centre.
  - New output port `o_parity_err` (1 bit, reset 0) pulses with `o_valid` when the XOR of the 8 data bits and the parity bit is 1.
  - `o_data` is still updated and `o_valid` still pulses.
  - Frame length becomes 11 bits; `o_valid` latency grows by CYCLES_PER_BAUD.
- When undefined: no PARITY state and no `o_parity_err` port; behaviour exactly as above.

Test Plan:
- Reset release, line idle high for 20000 cycles -> `o_busy`=0, `o_valid`=0, `o_data`=8'h00 throughout.
- Send 0x55 at 9600 baud with a good stop bit -> exactly one `o_valid` pulse, `o_data`=8'h55, within ±2 cycles of the computed latency; `o_busy` falls the same cycle.
- Send 0xA3 then 0x0F back-to-back with no idle gap -> two `o_valid` pulses, `o_data` 8'hA3 then 8'h0F, no `o_frame_err`.
- Drive `i_rx` low for 1000 cycles then high -> glitch rejected: FSM back in IDLE, no pulses, `o_busy` high for at most HALF_BAUD+3 cycles.
- Send 0x3C with stop bit low, then hold the line low for 3 bit periods before releasing -> exactly one `o_frame_err`, no `o_valid`, `o_data` keeps its prior value, `o_busy` high until the line returns high.
- Assert `i_rst_n`=0 for 2 cycles during data bit 4 of 0xFF, then send 0x81 -> no pulse for the aborted frame, one `o_valid` with `o_data`=8'h81; with UART_RX_PARITY_EN, 0x81 with parity bit 1 -> `o_parity_err`=1.
